// File: rtl/fns_rx_seq_decoder_pkg.sv
// Shared definitions for the FNS receiver decoder: default sizes for the 4_5
// configuration, FSM state encoding and the forbidden-transition rule.
package fns_pkg;

  localparam int FNS_N_TSV  = 9;
  localparam int FNS_DATA_W = 7;
  localparam int FNS_W_W    = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  // An odd line driven high next to an even line driven low is forbidden,
  // unless either line of the pair is disabled.
  function automatic logic ftf_check(input logic [FNS_N_TSV-1:0] tsv,
                                     input logic [FNS_N_TSV-1:0] en);
    logic [FNS_N_TSV:0] t_p;
    logic [FNS_N_TSV:0] e_p;
    logic               hit;
    t_p = {1'b0, tsv};
    e_p = {1'b0, en};
    hit = 1'b0;
    for (int k = 1; k < FNS_N_TSV; k += 2) begin
      hit |= t_p[k] & e_p[k] &
             ((e_p[k-1] & ~t_p[k-1]) | (e_p[k+1] & ~t_p[k+1]));
    end
    return hit;
  endfunction

endpackage

// File: rtl/fns_rx_seq_decoder_ftf_checker.sv
// Combinational forbidden-transition check over one TSV word.
module fns_ftf_checker
  import fns_pkg::*;
#(
  parameter int N_TSV = FNS_N_TSV
) (
  input  logic [N_TSV-1:0] tsv,
  input  logic [N_TSV-1:0] en_flag,
  output logic             ftf
);

  // Padding one line above the top keeps the odd-index scan uniform; the pad
  // is disabled so it can never complete a forbidden pair.
  logic [N_TSV:0] t_p;
  logic [N_TSV:0] e_p;

  always_comb begin
    t_p = {1'b0, tsv};
    e_p = {1'b0, en_flag};
    ftf = 1'b0;
    for (int k = 1; k < N_TSV; k += 2) begin
      ftf |= t_p[k] & e_p[k] &
             ((e_p[k-1] & ~t_p[k-1]) | (e_p[k+1] & ~t_p[k+1]));
    end
  end

endmodule

// File: rtl/fns_rx_seq_decoder.sv
// FNS receiver decoder: captures one TSV word, rebuilds the payload by serial
// weighted accumulation (top TSV first) and reports FTF and overflow errors.
module fns_rx_seq_decoder
  import fns_pkg::*;
#(
  parameter int N_TSV  = FNS_N_TSV,
  parameter int DATA_W = FNS_DATA_W,
  parameter int W_W    = FNS_W_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_TSV-1:0]       tsv,
  input  logic [N_TSV-1:0]       en_flag,
  input  logic [N_TSV*W_W-1:0]   fns_w,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      dataout,
  output logic                   ftf_err,
  output logic                   ovf_err
);

  localparam int IDX_W = (N_TSV > 1) ? $clog2(N_TSV) : 1;

  fsm_t                  state;
  logic [N_TSV-1:0]      tsv_q;
  logic [N_TSV-1:0]      en_q;
  logic [N_TSV*W_W-1:0]  w_q;
  logic [IDX_W-1:0]      idx;
  logic [DATA_W:0]       acc;
  logic                  ovf_q;
  logic                  ftf_q;
  logic                  ftf_now;

  logic [W_W-1:0]        w_cur;
  logic                  add_en;
  logic [DATA_W:0]       acc_next;

  fns_ftf_checker #(.N_TSV(N_TSV)) u_ftf (
    .tsv     (tsv),
    .en_flag (en_flag),
    .ftf     (ftf_now)
  );

  always_comb begin
    w_cur    = w_q[idx*W_W +: W_W];
    add_en   = en_q[idx] & tsv_q[idx];
    acc_next = add_en ? acc + (DATA_W+1)'(w_cur) : acc;
  end

  // Overflow is sticky because the accumulator top bit can wrap back to 0 on
  // later additions.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dataout   <= '0;
      ftf_err   <= 1'b0;
      ovf_err   <= 1'b0;
      tsv_q     <= '0;
      en_q      <= '0;
      w_q       <= '0;
      idx       <= '0;
      acc       <= '0;
      ovf_q     <= 1'b0;
      ftf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            tsv_q    <= tsv;
            en_q     <= en_flag;
            w_q      <= fns_w;
            ftf_q    <= ftf_now;
            acc      <= '0;
            ovf_q    <= 1'b0;
            idx      <= IDX_W'(N_TSV - 1);
            in_ready <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc   <= acc_next;
          ovf_q <= ovf_q | acc_next[DATA_W];
          if (idx == '0) begin
            dataout   <= acc_next[DATA_W-1:0];
            ovf_err   <= ovf_q | acc_next[DATA_W];
            ftf_err   <= ftf_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fns_rx_seq_decoder.sv
// Scoreboard bench for fns_rx_seq_decoder: directed words with hand-computed
// sums and error flags, plus latency, stall, ignore and reset-abort checks.
module tb_fns_rx_seq_decoder;
  import fns_pkg::*;

  localparam int N = 9;
  localparam int D = 7;
  localparam int W = 7;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   tsv = '0;
  logic [N-1:0]   en_flag = '0;
  logic [N*W-1:0] fns_w = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [D-1:0]   dataout;
  logic           ftf_err;
  logic           ovf_err;

  fns_rx_seq_decoder #(.N_TSV(N), .DATA_W(D), .W_W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tsv       (tsv),
    .en_flag   (en_flag),
    .fns_w     (fns_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataout   (dataout),
    .ftf_err   (ftf_err),
    .ovf_err   (ovf_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [D-1:0] data;
    logic         ftf;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [N*W-1:0] fib;
  logic [N*W-1:0] w127;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("dataout", 32'(dataout), 32'(e.data));
        check("ftf_err", 32'(ftf_err), 32'(e.ftf));
        check("ovf_err", 32'(ovf_err), 32'(e.ovf));
      end
    end
  end

  // Called and returns in the phase just after a rising edge.
  task automatic send(input logic [N-1:0] t, input logic [N-1:0] e,
                      input logic [N*W-1:0] w, input logic [D-1:0] d,
                      input logic f, input logic o, input bit push);
    int k;
    k = 0;
    while (!in_ready && k < 200) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    tsv      = t;
    en_flag  = e;
    fns_w    = w;
    in_valid = 1'b1;
    @(posedge clock);
    if (push) sb.push_back('{data: d, ftf: f, ovf: o});
    #1;
    in_valid = 1'b0;
    tsv      = ~t;
    en_flag  = '1;
    fns_w    = ~w;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    logic [W-1:0] f [N];
    f = '{1, 1, 2, 3, 5, 8, 13, 21, 34};
    for (int i = 0; i < N; i++) fib[i*W +: W] = f[i];
    w127 = {N{7'd127}};

    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready",  32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_dataout",   32'(dataout), 0);
    check("rst_ftf",       32'(ftf_err), 0);
    check("rst_ovf",       32'(ovf_err), 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Latency and handshake timing on the all-ones word.
    send(9'h1FF, 9'h1FF, fib, 7'd88, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("latency_negedges", 32'(n), 10);
    check("in_ready_in_done", 32'(in_ready), 0);
    @(negedge clock);
    check("out_valid_after_hs", 32'(out_valid), 0);
    check("in_ready_after_hs", 32'(in_ready), 1);
    @(posedge clock);
    #1;

    send(9'b101010101, 9'h1FF,       fib,  7'd55,  1'b0, 1'b0, 1'b1);
    send(9'b000000010, 9'h1FF,       fib,  7'd1,   1'b1, 1'b0, 1'b1);
    send(9'b000000010, 9'b111111101, fib,  7'd0,   1'b0, 1'b0, 1'b1);
    send(9'h1FF,       9'h1FF,       w127, 7'd119, 1'b0, 1'b1, 1'b1);
    send(9'b100000000, 9'h1FF,       fib,  7'd34,  1'b0, 1'b0, 1'b1);
    send(9'b010000000, 9'h1FF,       fib,  7'd21,  1'b1, 1'b0, 1'b1);
    send(9'b010000000, 9'b010111111, fib,  7'd21,  1'b0, 1'b0, 1'b1);
    send(9'b010000000, 9'b011111111, fib,  7'd21,  1'b1, 1'b0, 1'b1);
    send(9'b000000001, 9'h1FF,       w127, 7'd127, 1'b0, 1'b0, 1'b1);
    send(9'b000000011, 9'h1FF,       w127, 7'd126, 1'b1, 1'b1, 1'b1);
    send(9'h1FF,       9'b000001111, fib,  7'd7,   1'b0, 1'b0, 1'b1);
    drain();

    // Stall in DONE with stray in_valid pulses during ACCUM and DONE.
    out_ready = 1'b0;
    send(9'b100000010, 9'h1FF, fib, 7'd35, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    in_valid = 1'b1;
    tsv      = 9'h1FF;
    en_flag  = 9'h1FF;
    fns_w    = fib;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("stall_out_valid", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      @(posedge clock);
      #1;
      check("stall_dataout",   32'(dataout), 35);
      check("stall_ftf",       32'(ftf_err), 1);
      check("stall_ovf",       32'(ovf_err), 0);
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_in_ready",  32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clock);
      #1;
      if (out_valid || !in_ready) seen++;
    end
    check("ignored_pulses_idle", 32'(seen), 0);

    // Reset on the 4th ACCUM edge aborts the word.
    send(9'h1FF, 9'h1FF, fib, 7'd88, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_in_ready",  32'(in_ready), 1);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_dataout",   32'(dataout), 0);
    check("abort_ftf",       32'(ftf_err), 0);
    check("abort_ovf",       32'(ovf_err), 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_out_valid", 32'(seen), 0);
    send(9'b101010101, 9'h1FF, fib, 7'd55, 1'b0, 1'b0, 1'b1);
    drain();
    repeat (3) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fns_rx_seq_decoder.md
Name: fns_rx_seq_decoder

Overview:
Receiver-side, clocked counterpart of the FNS crosstalk-avoidance coder. It captures one N_TSV-bit word from the TSV bundle together with the enable flags and per-TSV Fibonacci weights produced by the receiver FNSadders instance. It then reconstructs the binary payload by serial weighted accumulation, one TSV per cycle, MSB TSV first. In the same pass it checks the captured word against the forbidden-transition pattern and reports overflow.

Parameters:
N_TSV, 9, number of TSV lines (x+y)
DATA_W, 7, decoded payload width (BLEN)
W_W, 7, width of each per-TSV FNS weight (FNSLEN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  TSV word and side information valid
in_ready  out  1  block can accept a word (IDLE only)
tsv  in  N_TSV  received TSV word; bit 0 is the first TSV
en_flag  in  N_TSV  1 = TSV enabled (non-faulty) and carrying weight
fns_w  in  N_TSV*W_W  flattened weights; slice i = weight of TSV i; disabled TSVs are don't-care
out_valid  out  1  decoded result valid
out_ready  in  1  consumer accepts result
dataout  out  DATA_W  decoded payload
ftf_err  out  1  forbidden-transition violation in the captured word
ovf_err  out  1  weighted sum ≥ 2^DATA_W

Behaviour:
- Interface decision: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: in_ready=1, out_valid=0, dataout=0, ftf_err=0, ovf_err=0; FSM goes to IDLE; accumulator and index are cleared.
- Reset wins over every other event, including reset asserted mid-ACCUM or during DONE. The in-flight word is discarded and no out_valid is produced for it.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: in_ready=1.
  - On an edge with in_valid=1: register tsv, en_flag and fns_w; acc=0; idx=N_TSV-1; go to ACCUM.
  - The combinational FTF check runs on the input word. Its result is registered into the ftf_err holding register at acceptance.
- ACCUM: in_ready=0. Each edge: if en_q[idx] & tsv_q[idx], then acc += w_q[idx].
  - acc is DATA_W+1 bits. The overflow bit is sticky.
  - If idx==0, go to DONE; otherwise idx--.
  - Exactly N_TSV ACCUM edges per word.
- DONE: out_valid=1. dataout = acc[DATA_W-1:0], ovf_err = sticky overflow, ftf_err = latched value.
  - All three outputs are registered and held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid drops to 0 and the FSM returns to IDLE. in_ready is high on the following cycle.
  - dataout and flags keep their last value after handshake.
- Latency: if a word is accepted at edge E, out_valid is first high after edge E+N_TSV. With out_ready tied high, throughput is one word per N_TSV+2 cycles.
- Input changes (tsv, en_flag, fns_w) after acceptance have no effect on the word in flight.
- FTF rule: for every odd index k, ftf_err is set if tsv[k]=1, en_flag[k]=1, and an even neighbour j∈{k-1,k+1}, j<N_TSV, has en_flag[j]=1 and tsv[j]=0.
  - Pairs with a disabled line are never flagged.
- Disabled TSVs contribute 0 regardless of their value or weight.
- Overflow: if any intermediate acc has bit DATA_W set, ovf_err=1. dataout is then the truncated low DATA_W bits.
- in_valid while not in IDLE is ignored; no capture and no error.

Decomposition:
- Shared package fns_pkg:
  - N_TSV/DATA_W/W_W defaults, matching the BLEN/FNSLEN values of the 4_5 configuration.
  - state enum fsm_t {IDLE, ACCUM, DONE}.
  - function ftf_check(tsv, en) returning 1 bit, reused by the sender-side monitor and benches.
- One sub-module is natural: fns_ftf_checker, the combinational FTF rule over N_TSV, instantiated once.
- Accumulator and FSM stay in the top.

Test Plan (fns_w for TSV8..TSV0 = 34,21,13,8,5,3,2,1,1; en_flag=9'h1FF unless noted):
- tsv=9'b111111111 accepted at edge E, out_ready=1 -> out_valid first high after edge E+9; dataout=88, ftf_err=0, ovf_err=0; in_ready high again two cycles later.
- tsv=9'b101010101 -> dataout=55, ftf_err=0. tsv=9'b000000010 -> dataout=1, ftf_err=1.
- en_flag=9'b111111101, tsv=9'b000000010 -> dataout=0, ftf_err=0 (disabled line excluded from both sum and FTF).
- All weights 127, tsv=9'h1FF -> ovf_err=1, dataout = 1143 mod 128 = 119.
- out_ready=0 for 5 cycles in DONE -> dataout/flags stable and in_ready=0 throughout. A new in_valid pulse during ACCUM or DONE is ignored; the next word is captured only after return to IDLE.
- reset asserted for 1 cycle at the 4th ACCUM edge -> next cycle in_ready=1 and all outputs 0; no out_valid for the aborted word. The following word decodes correctly.
